// File: rtl/song_sel_pkg.sv
// Shared types and constants for the song selector: FSM states, default mode and song count,
// and the wrap-around helpers used to step the song number.
package song_sel_pkg;

  localparam int NUM_W = 4;
  localparam int DEFAULT_NUM_SONGS = 3;
  localparam logic [2:0] DEFAULT_SEL_MODE = 3'b010;

  typedef enum logic [1:0] {IDLE, BROWSE, PLAY} state_t;

  function automatic logic [NUM_W-1:0] wrap_next(input logic [NUM_W-1:0] n,
                                                 input logic [NUM_W-1:0] max_n);
    return (n == max_n) ? NUM_W'(1) : n + NUM_W'(1);
  endfunction

  function automatic logic [NUM_W-1:0] wrap_prev(input logic [NUM_W-1:0] n,
                                                 input logic [NUM_W-1:0] max_n);
    return (n == NUM_W'(1)) ? max_n : n - NUM_W'(1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single push-button conditioner: two-flop synchronizer, stability counter and a registered
// one-cycle pulse on each accepted press (releases are silent).
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 2000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic sync1;
  logic sync2;
  logic level;
  logic level_d;
  logic [CW-1:0] cnt;

  // The counter only runs while the synced input disagrees with the accepted level, so any
  // return to agreement before LAST restarts the stability window from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      level_d <= level;
      press   <= level & ~level_d;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/song_selector.sv
// Song selector: debounced next/prev/ok buttons drive a wrap-around song number and a
// browse/play FSM. Optional macro SONG_SELECTOR_AUTO_ADVANCE_EN enables continuous playback.
module song_selector
  import song_sel_pkg::*;
#(
  parameter int NUM_SONGS = DEFAULT_NUM_SONGS,
  parameter int DEBOUNCE_CYCLES = 2000000,
  parameter logic [2:0] SEL_MODE = DEFAULT_SEL_MODE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       mode,
  input  logic             btn_next,
  input  logic             btn_prev,
  input  logic             btn_ok,
  input  logic             song_done,
  output logic [NUM_W-1:0] num,
  output logic             play_start,
  output logic             playing
);

  localparam logic [NUM_W-1:0] MAX_NUM = NUM_SONGS[NUM_W-1:0];

  logic next_p, prev_p, ok_p;
  logic next_q, prev_q, ok_q;
  state_t state;
`ifdef SONG_SELECTOR_AUTO_ADVANCE_EN
  logic restart_pending;
`endif

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk(clk), .reset(reset), .btn(btn_next), .press(next_p)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
    .clk(clk), .reset(reset), .btn(btn_prev), .press(prev_p)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ok (
    .clk(clk), .reset(reset), .btn(btn_ok), .press(ok_p)
  );

  // Press pulses are re-registered so the FSM sees all three aligned on the same cycle;
  // leaving SEL_MODE overrides everything else, including a pending auto-restart.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      next_q     <= 1'b0;
      prev_q     <= 1'b0;
      ok_q       <= 1'b0;
      state      <= IDLE;
      num        <= NUM_W'(1);
      play_start <= 1'b0;
      playing    <= 1'b0;
`ifdef SONG_SELECTOR_AUTO_ADVANCE_EN
      restart_pending <= 1'b0;
`endif
    end else begin
      next_q <= next_p;
      prev_q <= prev_p;
      ok_q   <= ok_p;
`ifdef SONG_SELECTOR_AUTO_ADVANCE_EN
      play_start      <= restart_pending;
      restart_pending <= 1'b0;
`else
      play_start <= 1'b0;
`endif
      if (mode != SEL_MODE) begin
        state      <= IDLE;
        playing    <= 1'b0;
        play_start <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= BROWSE;
          BROWSE: begin
            if (ok_q) begin
              state      <= PLAY;
              play_start <= 1'b1;
              playing    <= 1'b1;
            end else if (next_q && !prev_q) begin
              num <= wrap_next(num, MAX_NUM);
            end else if (prev_q && !next_q) begin
              num <= wrap_prev(num, MAX_NUM);
            end
          end
          PLAY: begin
            if (ok_q) begin
              state      <= BROWSE;
              playing    <= 1'b0;
              play_start <= 1'b0;
            end else if (song_done) begin
`ifdef SONG_SELECTOR_AUTO_ADVANCE_EN
              num             <= wrap_next(num, MAX_NUM);
              restart_pending <= 1'b1;
`else
              state   <= BROWSE;
              playing <= 1'b0;
`endif
            end
          end
          default: begin
            state   <= IDLE;
            playing <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_song_selector.sv
// Directed bench for song_selector with DEBOUNCE_CYCLES=4 and NUM_SONGS=3: a vector table of
// button presses plus hand-written play, mode and reset sequences.
module tb_song_selector;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] mode;
  logic       btn_next, btn_prev, btn_ok, song_done;
  logic [3:0] num;
  logic       play_start, playing;

  int checks = 0;
  int errors = 0;
  int ps_pulses = 0;
  int s0;

  typedef struct {
    logic       nxt;
    logic       prv;
    logic       ok;
    int         hold;
    logic [3:0] exp_num;
    logic       exp_playing;
    int         exp_starts;
    string      name;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  always @(posedge clk) if (play_start === 1'b1) ps_pulses++;

  song_selector #(.NUM_SONGS(3), .DEBOUNCE_CYCLES(4), .SEL_MODE(3'b010)) dut (
    .clk(clk), .reset(reset), .mode(mode),
    .btn_next(btn_next), .btn_prev(btn_prev), .btn_ok(btn_ok),
    .song_done(song_done), .num(num), .play_start(play_start), .playing(playing)
  );

  task automatic check_output(input string name, input logic [7:0] actual,
                              input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Holds the given buttons for 'hold' clocks, releases them and lets the release debounce settle.
  task automatic apply_stimulus(input logic n, input logic p, input logic o, input int hold);
    btn_next = n;
    btn_prev = p;
    btn_ok   = o;
    repeat (hold) @(negedge clk);
    btn_next = 1'b0;
    btn_prev = 1'b0;
    btn_ok   = 1'b0;
    repeat (14) @(negedge clk);
  endtask

  task automatic pulse_done();
    song_done = 1'b1;
    @(negedge clk);
    song_done = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 12, 4'd3, 1'b0, 0, "next_2_to_3"};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 12, 4'd1, 1'b0, 0, "next_wrap_3_to_1"};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 12, 4'd3, 1'b0, 0, "prev_wrap_1_to_3"};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 12, 4'd3, 1'b0, 0, "next_prev_same_edge"};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 3,  4'd3, 1'b0, 0, "glitch_ignored"};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 12, 4'd2, 1'b0, 0, "prev_3_to_2"};

    reset = 1'b1; mode = 3'b001;
    btn_next = 1'b0; btn_prev = 1'b0; btn_ok = 1'b0; song_done = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_num", 8'(num), 8'd1);
    check_output("reset_playing", 8'(playing), 8'd0);
    check_output("reset_play_start", 8'(play_start), 8'd0);
    reset = 1'b0;
    @(negedge clk);
    mode = 3'b010;
    repeat (2) @(negedge clk);

    // Latency: num must change on the 9th edge counting the first sampling edge as edge 0.
    btn_next = 1'b1;
    repeat (8) @(negedge clk);
    check_output("latency_not_early", 8'(num), 8'd1);
    @(negedge clk);
    check_output("latency_exact", 8'(num), 8'd2);
    repeat (3) @(negedge clk);
    btn_next = 1'b0;
    repeat (14) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      s0 = ps_pulses;
      apply_stimulus(vecs[i].nxt, vecs[i].prv, vecs[i].ok, vecs[i].hold);
      check_output({vecs[i].name, "_num"}, 8'(num), 8'(vecs[i].exp_num));
      check_output({vecs[i].name, "_playing"}, 8'(playing), 8'(vecs[i].exp_playing));
      check_output({vecs[i].name, "_starts"}, 8'(ps_pulses - s0), 8'(vecs[i].exp_starts));
    end

    // Enter PLAY with num=2.
    s0 = ps_pulses;
    btn_ok = 1'b1;
    repeat (9) @(negedge clk);
    check_output("ok_play_start_high", 8'(play_start), 8'd1);
    check_output("ok_playing", 8'(playing), 8'd1);
    @(negedge clk);
    check_output("ok_play_start_one_cycle", 8'(play_start), 8'd0);
    repeat (3) @(negedge clk);
    btn_ok = 1'b0;
    repeat (14) @(negedge clk);
    check_output("ok_single_pulse", 8'(ps_pulses - s0), 8'd1);

    apply_stimulus(1'b1, 1'b0, 1'b0, 12);
    check_output("play_next_ignored", 8'(num), 8'd2);
    check_output("play_still_playing", 8'(playing), 8'd1);

    pulse_done();
`ifdef SONG_SELECTOR_AUTO_ADVANCE_EN
    check_output("auto_adv_num", 8'(num), 8'd3);
    check_output("auto_adv_playing", 8'(playing), 8'd1);
    check_output("auto_adv_no_early_start", 8'(play_start), 8'd0);
    @(negedge clk);
    check_output("auto_adv_restart", 8'(play_start), 8'd1);
    apply_stimulus(1'b0, 1'b0, 1'b1, 12);
    check_output("auto_ok_stops", 8'(playing), 8'd0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 12);
    check_output("auto_browse_prev", 8'(num), 8'd2);
`else
    check_output("done_stops_playing", 8'(playing), 8'd0);
    check_output("done_no_restart", 8'(play_start), 8'd0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 12);
    check_output("browse_after_done", 8'(num), 8'd1);
    apply_stimulus(1'b1, 1'b0, 1'b0, 12);
    check_output("browse_back_to_2", 8'(num), 8'd2);
`endif

    // ok and next pressed together: ok wins, num stays.
    s0 = ps_pulses;
    apply_stimulus(1'b1, 1'b0, 1'b1, 12);
    check_output("ok_beats_next_num", 8'(num), 8'd2);
    check_output("ok_beats_next_playing", 8'(playing), 8'd1);
    check_output("ok_beats_next_starts", 8'(ps_pulses - s0), 8'd1);

    mode = 3'b001;
    @(negedge clk);
    check_output("mode_exit_playing", 8'(playing), 8'd0);
    check_output("mode_exit_num_held", 8'(num), 8'd2);
    apply_stimulus(1'b1, 1'b0, 1'b0, 12);
    check_output("idle_press_discarded", 8'(num), 8'd2);
    mode = 3'b010;
    repeat (2) @(negedge clk);
    apply_stimulus(1'b1, 1'b0, 1'b0, 12);
    check_output("browse_after_idle", 8'(num), 8'd3);
    check_output("browse_after_idle_playing", 8'(playing), 8'd0);

    apply_stimulus(1'b0, 1'b0, 1'b1, 12);
    check_output("replay_playing", 8'(playing), 8'd1);
`ifdef SONG_SELECTOR_AUTO_ADVANCE_EN
    pulse_done();
    check_output("auto_wrap_num", 8'(num), 8'd1);
    check_output("auto_wrap_playing", 8'(playing), 8'd1);
    @(negedge clk);
    check_output("auto_wrap_restart", 8'(play_start), 8'd1);
    @(negedge clk);
`endif

    s0 = ps_pulses;
    reset = 1'b1;
    #1;
    check_output("midplay_reset_num", 8'(num), 8'd1);
    check_output("midplay_reset_playing", 8'(playing), 8'd0);
    check_output("midplay_reset_play_start", 8'(play_start), 8'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check_output("post_reset_browse_num", 8'(num), 8'd1);
    check_output("post_reset_no_pulse", 8'(ps_pulses - s0), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/song_selector.md
Name: song_selector

Overview:
- Upstream stage of the song-number/name 7-segment display block: turns raw board buttons into the 4-bit song number `num` that the display consumes.
- Also issues play/stop control to the player.
- Debounces three buttons, keeps a wrap-around song index 1..NUM_SONGS and runs a browse/play state machine.
- Active only while the system mode equals SEL_MODE; the same `mode` bus also drives the display.

Parameters:
- NUM_SONGS, 3: number of selectable songs; valid range 1..15.
- DEBOUNCE_CYCLES, 2000000: consecutive stable clocks required to accept a button level change (20 ms at 100 MHz).
- SEL_MODE, 3'b010: `mode` value that enables selection.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- mode  input  3  system mode; the block is active only when mode == SEL_MODE.
- btn_next  input  1  raw push button (asynchronous), next song.
- btn_prev  input  1  raw push button (asynchronous), previous song.
- btn_ok  input  1  raw push button (asynchronous), play/stop toggle.
- song_done  input  1  one-cycle pulse from the player when the current song ends.
- num  output  4  current song number, 1..NUM_SONGS; never 0.
- play_start  output  1  one-cycle pulse requesting playback of `num`.
- playing  output  1  level, high while in PLAY.

Behaviour:
- Single clock domain: clk. Reset is asynchronous and active-high.
- Reset values: num=1, play_start=0, playing=0, FSM=IDLE, all debouncers report "released".
- Debounce, per button:
  - Two-flop synchronizer.
  - Counter increments each clock while the synced level differs from the debounced level, and clears to 0 when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level flips and the counter clears.
  - A rise of the debounced level produces a registered one-cycle press pulse. Releases produce no pulse.
  - Glitches shorter than DEBOUNCE_CYCLES are ignored.
- Latency: num changes exactly DEBOUNCE_CYCLES+4 clocks after the first clock edge that samples the raw button high.
- FSM states: IDLE, BROWSE, PLAY.
  - IDLE: mode != SEL_MODE. Press pulses are discarded; num is held. Goes to BROWSE on the clock after mode == SEL_MODE.
  - BROWSE:
    - next pulse: num = (num==NUM_SONGS) ? 1 : num+1.
    - prev pulse: num = (num==1) ? NUM_SONGS : num-1.
    - next and prev pulses in the same cycle: num unchanged.
    - ok pulse: go to PLAY, play_start=1 for exactly that transition cycle, playing=1. If ok coincides with next or prev, ok wins and num is unchanged.
  - PLAY:
    - next and prev are ignored; num is frozen.
    - ok pulse: go to BROWSE, playing=0.
    - song_done pulse: go to BROWSE, playing=0.
    - ok and song_done in the same cycle: go to BROWSE once; no restart.
  - Any state: mode != SEL_MODE moves to IDLE on the next clock, with playing=0 and play_start=0. This takes priority over all button pulses in that cycle.
- Width rule: num is 4 bits and compares against NUM_SONGS[3:0]. Values outside 1..NUM_SONGS are unreachable.
- Reset asserted mid-operation (e.g. during PLAY or mid-debounce): all state returns to reset values immediately; no pulse is emitted on release.
- play_start and playing are registered outputs with no combinational path from inputs.

Optional Feature:
- Macro: SONG_SELECTOR_AUTO_ADVANCE_EN.
- Defined: a song_done pulse in PLAY advances num with next-wrap rules, stays in PLAY, and pulses play_start on the following cycle. Continuous playback wraps from NUM_SONGS to 1.
- Undefined: song_done returns to BROWSE as described above.
- ok in PLAY stops playback in both builds.

Decomposition:
- Package song_sel_pkg:
  - state enum {IDLE, BROWSE, PLAY};
  - SEL_MODE constant 3'b010;
  - default NUM_SONGS;
  - width constant NUM_W=4.
- Sub-module btn_debounce (synchronizer, stability counter, rise pulse), parameterised by DEBOUNCE_CYCLES and instantiated three times.
- The top holds the FSM and the num register.

Test Plan (DEBOUNCE_CYCLES=4, NUM_SONGS=3):
- mode=3'b010, btn_next held high 12 clocks, repeated three times -> num goes 1→2→3→1. Each change occurs 8 clocks after the raw rise.
- num=1, btn_prev press -> num=3. Next and prev raised on the same edge and held -> num unchanged.
- btn_next high for 3 clocks only (glitch) -> no num change, no pulse.
- num=2, btn_ok press -> play_start high exactly one cycle, playing=1. Then btn_next press -> num stays 2. Then song_done pulse -> playing=0, FSM in BROWSE.
- In PLAY, mode changed to 3'b001 -> playing=0 the next clock and num held at 2. mode back to 3'b010 -> BROWSE; btn_next press -> num=3.
- reset pulsed during PLAY with num=3 -> num=1, playing=0 and play_start=0 immediately. With SONG_SELECTOR_AUTO_ADVANCE_EN: in PLAY with num=3, song_done -> num=1 and a play_start pulse one cycle later, playing stays 1.
